// File: rtl/uc_pkg.sv
// Shared types and opcode constants for the multicycle control unit.
package uc_pkg;

   localparam int unsigned OPC_W    = 6;
   localparam int unsigned ALU_OP_W = 3;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [OPC_W-1:0] OP_NOP = 6'b000000;
   localparam logic [OPC_W-1:0] OP_J   = 6'b010000;
   localparam logic [OPC_W-1:0] OP_JZ  = 6'b010001;
   localparam logic [OPC_W-1:0] OP_JNZ = 6'b010010;

   // Prefix classes: ALU is 1xxxxx, li is 0001xx
   localparam logic [OPC_W-1:0] ALU_MASK  = 6'b100000;
   localparam logic [OPC_W-1:0] ALU_MATCH = 6'b100000;
   localparam logic [OPC_W-1:0] LI_MASK   = 6'b111100;
   localparam logic [OPC_W-1:0] LI_MATCH  = 6'b000100;

   typedef struct packed {
      logic                s_inc;
      logic                s_inm;
      logic                we3;
      logic                wez;
      logic [ALU_OP_W-1:0] op;
      logic                pc_en;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   function automatic logic is_alu(input logic [OPC_W-1:0] opc);
      return (opc & ALU_MASK) == ALU_MATCH;
   endfunction

   function automatic logic is_li(input logic [OPC_W-1:0] opc);
      return (opc & LI_MASK) == LI_MATCH;
   endfunction

   function automatic logic is_legal(input logic [OPC_W-1:0] opc);
      return is_alu(opc) || is_li(opc) || (opc == OP_NOP) ||
             (opc == OP_J) || (opc == OP_JZ) || (opc == OP_JNZ);
   endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational EXEC-phase decode of opcode and sampled zero flag into datapath controls.
import uc_pkg::*;

module uc_decode (
   input  logic [OPC_W-1:0] ir,
   input  logic             z_q,
   input  logic             legal,
   output ctrl_t            ctrl_c
);

   always_comb begin
      ctrl_c       = CTRL_IDLE;
      ctrl_c.pc_en = 1'b1;
      ctrl_c.s_inc = 1'b1;
      // Illegal opcodes fall through as a nop
      if (legal) begin
         if (is_alu(ir)) begin
            ctrl_c.we3 = 1'b1;
            ctrl_c.wez = 1'b1;
            ctrl_c.op  = ir[ALU_OP_W-1:0];
         end else if (is_li(ir)) begin
            ctrl_c.s_inm = 1'b1;
            ctrl_c.we3   = 1'b1;
         end else begin
            unique case (ir)
               OP_J:    ctrl_c.s_inc = 1'b0;
               OP_JZ:   ctrl_c.s_inc = ~z_q;
               OP_JNZ:  ctrl_c.s_inc = z_q;
               default: ctrl_c.s_inc = 1'b1;
            endcase
         end
      end
   end

endmodule

// File: rtl/uc_multiciclo.sv
// Two-cycle (FETCH/EXEC) control unit for microc with PC enable, halt state and retire counter.
// Optional: define UC_ILLEGAL_HALT_EN to halt on illegal opcodes instead of treating them as nop.
import uc_pkg::*;

module uc_multiciclo #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OPC_W-1:0] Opcode,
   input  logic             z,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       Op,
   output logic             pc_en,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt
);

   state_t            state, state_nx;
   logic [OPC_W-1:0]  ir, ir_nx;
   logic              z_q, z_nx;
   logic              legal_c;
   ctrl_t             ctrl, ctrl_nx, dec_ctrl_c;
   logic [CNT_W-1:0]  cnt, cnt_nx;

   // Instruction and flag are captured only in FETCH; decode looks at the next-cycle values
   // so the control outputs can be registered and valid throughout EXEC.
   assign ir_nx   = (state == FETCH) ? Opcode : ir;
   assign z_nx    = (state == FETCH) ? z      : z_q;
   assign legal_c = is_legal(ir_nx);

   uc_decode u_decode (
      .ir     (ir_nx),
      .z_q    (z_nx),
      .legal  (legal_c),
      .ctrl_c (dec_ctrl_c)
   );

`ifdef UC_ILLEGAL_HALT_EN
   logic halted_q, halted_nx;
`endif

   // Next-state, next-output and counter logic
   always_comb begin
      state_nx = state;
      ctrl_nx  = CTRL_IDLE;
      cnt_nx   = cnt;
`ifdef UC_ILLEGAL_HALT_EN
      halted_nx = 1'b0;
`endif
      unique case (state)
         FETCH: begin
`ifdef UC_ILLEGAL_HALT_EN
            if (!legal_c) begin
               state_nx  = HALT;
               halted_nx = 1'b1;
            end else begin
               state_nx = EXEC;
               ctrl_nx  = dec_ctrl_c;
            end
`else
            state_nx = EXEC;
            ctrl_nx  = dec_ctrl_c;
`endif
         end
         EXEC: begin
            state_nx = FETCH;
            cnt_nx   = (&cnt) ? cnt : cnt + CNT_W'(1);
         end
         HALT: begin
            state_nx = HALT;
`ifdef UC_ILLEGAL_HALT_EN
            halted_nx = 1'b1;
`endif
         end
         default: state_nx = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         ir    <= '0;
         z_q   <= 1'b0;
         ctrl  <= CTRL_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         ir    <= ir_nx;
         z_q   <= z_nx;
         ctrl  <= ctrl_nx;
         cnt   <= cnt_nx;
      end
   end

`ifdef UC_ILLEGAL_HALT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) halted_q <= 1'b0;
      else       halted_q <= halted_nx;
   end
   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

   assign s_inc     = ctrl.s_inc;
   assign s_inm     = ctrl.s_inm;
   assign we3       = ctrl.we3;
   assign wez       = ctrl.wez;
   assign Op        = ctrl.op;
   assign pc_en     = ctrl.pc_en;
   assign instr_cnt = cnt;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo: driver queues expected EXEC controls, monitor checks on pc_en.
module tb_uc_multiciclo;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CNT_MAX = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       Opcode;
   logic             z;
   logic             s_inc, s_inm, we3, wez, pc_en, halted;
   logic [2:0]       Op;
   logic [CNT_W-1:0] instr_cnt;

   uc_multiciclo #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .Opcode    (Opcode),
      .z         (z),
      .s_inc     (s_inc),
      .s_inm     (s_inm),
      .we3       (we3),
      .wez       (wez),
      .Op        (Op),
      .pc_en     (pc_en),
      .halted    (halted),
      .instr_cnt (instr_cnt)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic             s_inc;
      logic             s_inm;
      logic             we3;
      logic             wez;
      logic             chk_op;
      logic [2:0]       op;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;
   int    exp_cnt = 0;
   logic  prev_pc_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every EXEC (pc_en high) consumes one scoreboard entry
   always @(negedge clk) begin
      exp_t  e;
      string t;
      if (reset) begin
         prev_pc_en = 1'b0;
      end else begin
         if (pc_en) begin
            check("pc_en_single_cycle", 32'(prev_pc_en), 32'd0);
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_exec: pc_en high with no queued instruction");
            end else begin
               e = sb_q.pop_front();
               t = tag_q.pop_front();
               check({t, ".s_inc"}, 32'(s_inc), 32'(e.s_inc));
               check({t, ".s_inm"}, 32'(s_inm), 32'(e.s_inm));
               check({t, ".we3"},   32'(we3),   32'(e.we3));
               check({t, ".wez"},   32'(wez),   32'(e.wez));
               check({t, ".cnt"},   32'(instr_cnt), 32'(e.cnt));
               if (e.chk_op) check({t, ".Op"}, 32'(Op), 32'(e.op));
            end
         end
         prev_pc_en = pc_en;
      end
   end

   // Called in a FETCH cycle; returns at the negedge of the following FETCH cycle
   task automatic issue(input string tag, input logic [5:0] opc, input logic zv,
                        input logic e_inc, input logic e_inm, input logic e_we3,
                        input logic e_wez, input logic e_chk, input logic [2:0] e_op);
      exp_t e;
      Opcode   = opc;
      z        = zv;
      e.s_inc  = e_inc;
      e.s_inm  = e_inm;
      e.we3    = e_we3;
      e.wez    = e_wez;
      e.chk_op = e_chk;
      e.op     = e_op;
      e.cnt    = CNT_W'(exp_cnt);
      sb_q.push_back(e);
      tag_q.push_back(tag);
      exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.outputs", 32'({s_inc, s_inm, we3, wez, pc_en, halted, Op}), 32'd0);
      check("rst.cnt", 32'(instr_cnt), 32'd0);
      reset   = 1'b0;
      exp_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset  = 1'b1;
      Opcode = 6'b100010;
      z      = 1'b0;
      do_reset();
      #1 check("fetch.idle", 32'({we3, wez, pc_en, Op}), 32'd0);

      issue("alu",  6'b100010, 1'b0, 1, 0, 1, 1, 1, 3'b010);
      check("alu.cnt_after", 32'(instr_cnt), 32'd1);
      issue("li",   6'b000101, 1'b0, 1, 1, 1, 0, 0, 3'b000);
      issue("jz_z1",  6'b010001, 1'b1, 0, 0, 0, 0, 0, 3'b000);
      issue("jz_z0",  6'b010001, 1'b0, 1, 0, 0, 0, 0, 3'b000);
      issue("jnz_z1", 6'b010010, 1'b1, 1, 0, 0, 0, 0, 3'b000);
      issue("jnz_z0", 6'b010010, 1'b0, 0, 0, 0, 0, 0, 3'b000);
      issue("j",    6'b010000, 1'b1, 0, 0, 0, 0, 0, 3'b000);
      issue("nop",  6'b000000, 1'b0, 1, 0, 0, 0, 0, 3'b000);
      check("cnt_after_8", 32'(instr_cnt), 32'd8);

      // Illegal opcode
`ifdef UC_ILLEGAL_HALT_EN
      Opcode = 6'b011111;
      @(posedge clk);
      #1 check("illegal.halted", 32'({halted, pc_en, we3, wez}), 32'b1000);
      repeat (3) @(posedge clk);
      #1 check("halt.held", 32'({halted, pc_en}), 32'b10);
      check("halt.cnt_frozen", 32'(instr_cnt), 32'd8);
      @(negedge clk);
`else
      issue("illegal_nop", 6'b011111, 1'b0, 1, 0, 0, 0, 1, 3'b000);
      check("illegal.cnt", 32'(instr_cnt), 32'd9);
      check("illegal.not_halted", 32'(halted), 32'd0);
`endif

      // Reset in the middle of an ALU EXEC
      do_reset();
      issue("nop_pre", 6'b000000, 1'b0, 1, 0, 0, 0, 0, 3'b000);
      Opcode = 6'b100011;
      @(posedge clk);
      #1 check("midexec.active", 32'({we3, wez, pc_en, Op}), 32'b111011);
      #2 reset = 1'b1;
      #1 check("midexec.dropped", 32'({we3, wez, pc_en, s_inc}), 32'd0);
      check("midexec.cnt", 32'(instr_cnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b0;
      exp_cnt = 0;

      // Saturation of the 4-bit retire counter
      for (int i = 0; i < 20; i++)
         issue("nop_sat", 6'b000000, 1'b0, 1, 0, 0, 0, 0, 3'b000);
      check("sat.cnt", 32'(instr_cnt), 32'(CNT_MAX));

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Control unit for the `microc` datapath: consumes `Opcode`/`z`, produces `s_inc`, `s_inm`, `we3`, `wez`, `Op`.
- Multicycle, two cycles per instruction (FETCH, EXEC), so datapath writes happen only in EXEC.
- Adds a PC enable (`pc_en`), a halt state and a retired-instruction counter.
- Sits beside `microc` at the top level. `pc_en` gates the PC register load in the datapath.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Opcode  input  6  instruction opcode from the datapath (instruction memory output).
- z  input  1  zero flag from the datapath flag register.
- s_inc  output  1  1 = PC+1, 0 = jump target.
- s_inm  output  1  1 = write-back source is the immediate, 0 = ALU.
- we3  output  1  register-file write enable.
- wez  output  1  zero-flag write enable.
- Op  output  3  ALU operation.
- pc_en  output  1  PC load enable.
- halted  output  1  high while in HALT.
- instr_cnt  output  CNT_W  number of retired instructions.

Behaviour:
- Reset:
  - Asynchronous; state goes to FETCH.
  - `ir`, `z_q` and `instr_cnt` are cleared.
  - All outputs are 0: `s_inc`, `s_inm`, `we3`, `wez`, `pc_en`, `halted`, and `Op`=000.
  - Reset mid-instruction aborts it; no write enable may glitch high during reset.
- FETCH (1 cycle):
  - Latch `ir`<=`Opcode` and `z_q`<=`z`.
  - All enables 0, `s_inc`=0, `Op`=000.
  - Next state is EXEC, or HALT if the opcode is illegal (see Optional Feature).
- EXEC (1 cycle):
  - Outputs are a Moore decode of `ir`/`z_q`; `pc_en`=1.
  - `instr_cnt` increments at the end of EXEC and saturates at all-ones.
  - Next state is FETCH.
- Decode in EXEC:
  - 1xxxxx (ALU): `s_inc`=1, `we3`=1, `wez`=1, `s_inm`=0, `Op`=`ir`[2:0].
  - 0001xx (li): `s_inc`=1, `s_inm`=1, `we3`=1, `wez`=0.
  - 000000 (nop): `s_inc`=1, no writes.
  - 010000 (j): `s_inc`=0, no writes.
  - 010001 (jz): `s_inc`=~`z_q`, so it jumps when `z_q`=1. No writes.
  - 010010 (jnz): `s_inc`=`z_q`, so it jumps when `z_q`=0. No writes.
  - All other opcodes are illegal.
- Flag timing: `z_q` is sampled in FETCH, so a jz/jnz sees the flag written by the previous instruction's EXEC.
- HALT:
  - `halted`=1, `pc_en`=0, all write enables 0, `Op`=000.
  - Held until reset; `instr_cnt` frozen.
- Latency: exactly 2 cycles per instruction, independent of opcode and of whether a branch is taken.
- Outputs are registered state/`ir` decode and do not change combinationally with `Opcode` or `z`.

Optional Feature:
- Macro: UC_ILLEGAL_HALT_EN.
- Defined: an illegal opcode in FETCH goes to HALT; `instr_cnt` does not count it.
- Undefined: an illegal opcode executes as a nop (`s_inc`=1, `pc_en`=1, no writes) and is counted. HALT is unreachable and `halted` is tied to 0.

Decomposition:
- Shared package `uc_pkg`:
  - state enum {FETCH, EXEC, HALT} (2 bits);
  - opcode constants OP_NOP=6'b000000, OP_J=6'b010000, OP_JZ=6'b010001, OP_JNZ=6'b010010;
  - prefix masks for ALU (1xxxxx) and li (0001xx).
- One sub-module, `uc_decode`: combinational decode of (`ir`, `z_q`, `legal`) into the control outputs. It is reused by the FSM top, which owns state, `ir`, `z_q` and the counter.

Test Plan:
- Reset held 3 cycles then released, `Opcode`=6'b100010 -> `Op`=000 and all enables 0 until first FETCH; EXEC cycle gives `we3`=1, `wez`=1, `Op`=010, `pc_en`=1; `instr_cnt`=1.
- li 6'b000101 -> EXEC: `s_inm`=1, `we3`=1, `wez`=0, `s_inc`=1.
- jz with `z`=1 at FETCH -> EXEC `s_inc`=0. jz with `z`=0 -> `s_inc`=1. jnz gives the mirror result. No write enables in either case.
- Opcode 6'b011111 with UC_ILLEGAL_HALT_EN -> `halted`=1 from the next cycle, `pc_en`=0, `instr_cnt` unchanged. Without the macro -> nop, `instr_cnt`+1.
- Reset asserted mid-EXEC of an ALU op -> `we3`/`wez`/`pc_en` drop immediately (asynchronously), `instr_cnt`=0, restart in FETCH.
- CNT_W=4, 20 nops -> `instr_cnt` saturates at 15; every EXEC asserts `pc_en` for exactly 1 cycle every 2 cycles.
